// File: rtl/l15_req_arbiter.sv
// L1.5 request front-end: one 1-deep pending buffer per source channel, arbitrated
// (round-robin or fixed priority) into a single registered request slot held until l15_ack.

module l15_req_chan #(
  parameter int AW   = 40,
  parameter bit SWAP = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          val,
  input  logic          grant,
  input  logic [4:0]    rqtype,
  input  logic [2:0]    size,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   data,
  output logic          pend,
  output logic [4:0]    pend_rqtype,
  output logic [2:0]    pend_size,
  output logic [AW-1:0] pend_addr,
  output logic [63:0]   pend_data
);
  logic          pend_q, pend_d;
  logic [4:0]    rqtype_q, rqtype_d;
  logic [2:0]    size_q, size_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [63:0]   data_q, data_d;
  logic [63:0]   data_in;

  always_comb begin
    data_in = data;
    if (SWAP) begin
      for (int b = 0; b < 8; b++) data_in[8*b +: 8] = data[8*(7-b) +: 8];
    end
  end

  // Capture only when empty, so capture and grant never hit the same edge.
  always_comb begin
    pend_d   = pend_q;
    rqtype_d = rqtype_q;
    size_d   = size_q;
    addr_d   = addr_q;
    data_d   = data_q;
    if (grant) pend_d = 1'b0;
    if (val && !pend_q) begin
      pend_d   = 1'b1;
      rqtype_d = rqtype;
      size_d   = size;
      addr_d   = addr;
      data_d   = data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q   <= 1'b0;
      rqtype_q <= '0;
      size_q   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      pend_q   <= pend_d;
      rqtype_q <= rqtype_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign pend        = pend_q;
  assign pend_rqtype = rqtype_q;
  assign pend_size   = size_q;
  assign pend_addr   = addr_q;
  assign pend_data   = data_q;
endmodule

module l15_req_arbiter #(
  parameter int             NUM_CH         = 3,
  parameter int             PHY_ADDR_WIDTH = 40,
  parameter bit             ARB_RR         = 1'b1,
  parameter logic [7:0]     BSWAP_MASK     = 8'b0000_0100,
  parameter int             CHID_W         = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_CH-1:0]                     ch_val,
  output logic [NUM_CH-1:0]                     ch_rdy,
  input  logic [NUM_CH-1:0][4:0]                ch_rqtype,
  input  logic [NUM_CH-1:0][2:0]                ch_size,
  input  logic [NUM_CH-1:0][PHY_ADDR_WIDTH-1:0] ch_addr,
  input  logic [NUM_CH-1:0][63:0]               ch_data,
  output logic [NUM_CH-1:0]                     ch_done,
  input  logic                                  l15_ack,
  output logic                                  l15_val,
  output logic [4:0]                            l15_rqtype,
  output logic [2:0]                            l15_size,
  output logic [PHY_ADDR_WIDTH-1:0]             l15_address,
  output logic [63:0]                           l15_data,
  output logic                                  l15_nc,
  output logic [CHID_W-1:0]                     l15_chid,
  output logic                                  l15_threadid,
  output logic                                  l15_prefetch,
  output logic                                  l15_blockstore,
  output logic                                  l15_blockinitstore,
  output logic                                  l15_invalidate_cacheline,
  output logic [1:0]                            l15_l1rplway,
  output logic [32:0]                           l15_csm_data,
  output logic [63:0]                           l15_data_next_entry
);
  typedef struct packed {
    logic [4:0]                rqtype;
    logic [2:0]                size;
    logic [PHY_ADDR_WIDTH-1:0] addr;
    logic [63:0]               data;
    logic [CHID_W-1:0]         chid;
  } req_t;

  logic [NUM_CH-1:0]                     pend, grant;
  logic [NUM_CH-1:0][4:0]                p_rqtype;
  logic [NUM_CH-1:0][2:0]                p_size;
  logic [NUM_CH-1:0][PHY_ADDR_WIDTH-1:0] p_addr;
  logic [NUM_CH-1:0][63:0]               p_data;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    l15_req_chan #(.AW(PHY_ADDR_WIDTH), .SWAP(BSWAP_MASK[i])) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .val        (ch_val[i]),
      .grant      (grant[i]),
      .rqtype     (ch_rqtype[i]),
      .size       (ch_size[i]),
      .addr       (ch_addr[i]),
      .data       (ch_data[i]),
      .pend       (pend[i]),
      .pend_rqtype(p_rqtype[i]),
      .pend_size  (p_size[i]),
      .pend_addr  (p_addr[i]),
      .pend_data  (p_data[i])
    );
  end

  logic              val_q, val_d;
  req_t              slot_q, slot_d, win_req;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [CHID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CHID_W-1:0] win_idx;
  logic              win_vld, slot_free, load;

  assign ch_rdy    = ~pend;
  assign slot_free = ~val_q | l15_ack;

  // RR: scan distances farthest-to-nearest from the pointer so the nearest pending wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    if (ARB_RR) begin
      for (int k = NUM_CH; k >= 1; k--) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (pend[c] && (c == (int'(rr_ptr_q) + k) % NUM_CH)) begin
            win_vld = 1'b1;
            win_idx = CHID_W'(c);
          end
        end
      end
    end else begin
      for (int c = NUM_CH - 1; c >= 0; c--) begin
        if (pend[c]) begin
          win_vld = 1'b1;
          win_idx = CHID_W'(c);
        end
      end
    end
  end

  assign load = slot_free & win_vld;

  always_comb begin
    win_req = '0;
    grant   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (win_idx == CHID_W'(c)) begin
        win_req.rqtype = p_rqtype[c];
        win_req.size   = p_size[c];
        win_req.addr   = p_addr[c];
        win_req.data   = p_data[c];
        grant[c]       = load;
      end
    end
    win_req.chid = win_idx;
  end

  always_comb begin
    val_d    = val_q;
    slot_d   = slot_q;
    rr_ptr_d = rr_ptr_q;
    if (slot_free) begin
      val_d = win_vld;
      if (win_vld) begin
        slot_d   = win_req;
        rr_ptr_d = win_idx;
      end
    end
    done_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      done_d[c] = l15_ack && val_q && (slot_q.chid == CHID_W'(c));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      val_q    <= 1'b0;
      slot_q   <= '0;
      done_q   <= '0;
      rr_ptr_q <= CHID_W'(NUM_CH - 1);
    end else begin
      val_q    <= val_d;
      slot_q   <= slot_d;
      done_q   <= done_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign ch_done     = done_q;
  assign l15_val     = val_q;
  assign l15_rqtype  = slot_q.rqtype;
  assign l15_size    = slot_q.size;
  assign l15_address = slot_q.addr;
  assign l15_data    = slot_q.data;
  assign l15_chid    = slot_q.chid;
  assign l15_nc      = slot_q.addr[PHY_ADDR_WIDTH-1];

  assign l15_threadid             = 1'b0;
  assign l15_prefetch             = 1'b0;
  assign l15_blockstore           = 1'b0;
  assign l15_blockinitstore       = 1'b0;
  assign l15_invalidate_cacheline = 1'b0;
  assign l15_l1rplway             = 2'b0;
  assign l15_csm_data             = 33'b0;
  assign l15_data_next_entry      = 64'b0;
endmodule

// File: tb/tb_l15_req_arbiter.sv
// Bench for l15_req_arbiter: a round-robin and a fixed-priority instance share stimulus;
// expected grants are queued per instance and checked when the L1.5 side accepts them.

module tb_l15_req_arbiter;
  localparam int         N    = 3;
  localparam int         AW   = 40;
  localparam logic [2:0] BSW  = 3'b100;
  localparam logic [4:0] IMISS_RQ = 5'b10000;
  localparam logic [4:0] LOAD_RQ  = 5'b00000;
  localparam logic [4:0] STORE_RQ = 5'b00001;

  typedef struct packed {
    logic [1:0]    chid;
    logic [4:0]    rqtype;
    logic [2:0]    size;
    logic [AW-1:0] addr;
    logic [63:0]   data;
    logic          nc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, ack;
  logic [N-1:0]           ch_val;
  logic [N-1:0][4:0]      ch_rqtype;
  logic [N-1:0][2:0]      ch_size;
  logic [N-1:0][AW-1:0]   ch_addr;
  logic [N-1:0][63:0]     ch_data;

  logic [N-1:0]  rdy_r, done_r, rdy_f, done_f;
  logic          val_r, nc_r, val_f, nc_f;
  logic [4:0]    rq_r, rq_f;
  logic [2:0]    sz_r, sz_f;
  logic [AW-1:0] ad_r, ad_f;
  logic [63:0]   d_r, d_f, dn_r, dn_f;
  logic [1:0]    id_r, id_f, way_r, way_f;
  logic          t0_r, t1_r, t2_r, t3_r, t4_r, t0_f, t1_f, t2_f, t3_f, t4_f;
  logic [32:0]   csm_r, csm_f;

  int n_assert = 0;
  int n_fail   = 0;
  exp_t q_rr[$];
  exp_t q_fp[$];

  always #5 clk = ~clk;

  l15_req_arbiter #(.NUM_CH(N), .PHY_ADDR_WIDTH(AW), .ARB_RR(1'b1),
                    .BSWAP_MASK({5'b0, BSW}), .CHID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .ch_val(ch_val), .ch_rdy(rdy_r), .ch_rqtype(ch_rqtype),
    .ch_size(ch_size), .ch_addr(ch_addr), .ch_data(ch_data), .ch_done(done_r),
    .l15_ack(ack), .l15_val(val_r), .l15_rqtype(rq_r), .l15_size(sz_r),
    .l15_address(ad_r), .l15_data(d_r), .l15_nc(nc_r), .l15_chid(id_r),
    .l15_threadid(t0_r), .l15_prefetch(t1_r), .l15_blockstore(t2_r),
    .l15_blockinitstore(t3_r), .l15_invalidate_cacheline(t4_r),
    .l15_l1rplway(way_r), .l15_csm_data(csm_r), .l15_data_next_entry(dn_r));

  l15_req_arbiter #(.NUM_CH(N), .PHY_ADDR_WIDTH(AW), .ARB_RR(1'b0),
                    .BSWAP_MASK({5'b0, BSW}), .CHID_W(2)) dut_fp (
    .clk(clk), .rst_n(rst_n), .ch_val(ch_val), .ch_rdy(rdy_f), .ch_rqtype(ch_rqtype),
    .ch_size(ch_size), .ch_addr(ch_addr), .ch_data(ch_data), .ch_done(done_f),
    .l15_ack(ack), .l15_val(val_f), .l15_rqtype(rq_f), .l15_size(sz_f),
    .l15_address(ad_f), .l15_data(d_f), .l15_nc(nc_f), .l15_chid(id_f),
    .l15_threadid(t0_f), .l15_prefetch(t1_f), .l15_blockstore(t2_f),
    .l15_blockinitstore(t3_f), .l15_invalidate_cacheline(t4_f),
    .l15_l1rplway(way_f), .l15_csm_data(csm_f), .l15_data_next_entry(dn_f));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk_exp(input int ch);
    exp_t e;
    logic [63:0] raw;
    raw      = ch_data[ch];
    e.chid   = 2'(ch);
    e.rqtype = ch_rqtype[ch];
    e.size   = ch_size[ch];
    e.addr   = ch_addr[ch];
    e.data   = BSW[ch] ? {<<8{raw}} : raw;
    e.nc     = ch_addr[ch][AW-1];
    return e;
  endfunction

  task automatic push(input int ch_rr, input int ch_fp);
    q_rr.push_back(mk_exp(ch_rr));
    q_fp.push_back(mk_exp(ch_fp));
  endtask

  task automatic check_acc(input string p, input exp_t e, input logic [1:0] id,
                           input logic [4:0] rq, input logic [2:0] sz,
                           input logic [AW-1:0] ad, input logic [63:0] d, input logic nc);
    chk({p, "_chid"}, 64'(id), 64'(e.chid));
    chk({p, "_rqtype"}, 64'(rq), 64'(e.rqtype));
    chk({p, "_size"}, 64'(sz), 64'(e.size));
    chk({p, "_addr"}, 64'(ad), 64'(e.addr));
    chk({p, "_data"}, d, e.data);
    chk({p, "_nc"}, 64'(nc), 64'(e.nc));
  endtask

  // Accepted transfer = valid & ack seen before the edge, outside reset.
  always @(negedge clk) begin
    if (rst_n && ack && val_r) begin
      chk("rr_expected_pending", 64'(q_rr.size() != 0), 64'd1);
      if (q_rr.size() != 0) check_acc("rr", q_rr.pop_front(), id_r, rq_r, sz_r, ad_r, d_r, nc_r);
    end
    if (rst_n && ack && val_f) begin
      chk("fp_expected_pending", 64'(q_fp.size() != 0), 64'd1);
      if (q_fp.size() != 0) check_acc("fp", q_fp.pop_front(), id_f, rq_f, sz_f, ad_f, d_f, nc_f);
    end
  end

  initial begin
    rst_n = 1'b0; ack = 1'b0; ch_val = '0;
    ch_rqtype = '0; ch_size = '0; ch_addr = '0; ch_data = '0;
    tick(); tick();
    chk("rst_val", 64'(val_r), 64'd0);
    chk("rst_val_fp", 64'(val_f), 64'd0);
    chk("rst_rdy", 64'(rdy_r), 64'd7);
    chk("rst_done", 64'(done_r), 64'd0);
    chk("rst_addr", 64'(ad_r), 64'd0);
    chk("rst_data", d_r, 64'd0);
    chk("rst_chid", 64'(id_r), 64'd0);
    chk("rst_rqtype", 64'(rq_r), 64'd0);
    chk("tied_csm", 64'(csm_r), 64'd0);
    chk("tied_misc", 64'({t0_r, t1_r, t2_r, t3_r, t4_r, way_r}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single IMISS on ch0, held without ack, then acked.
    ch_rqtype[0] = IMISS_RQ; ch_size[0] = 3'b010; ch_addr[0] = 40'h00_0000_1240;
    ch_data[0] = 64'hDEAD_BEEF_0000_0001;
    push(0, 0);
    ch_val = 3'b001;
    tick();
    ch_val = '0;
    chk("s1_val_e0", 64'(val_r), 64'd0);
    chk("s1_rdy_e0", 64'(rdy_r), 64'd6);
    tick();
    chk("s1_val_e1", 64'(val_r), 64'd1);
    chk("s1_rdy_e1", 64'(rdy_r), 64'd7);
    chk("s1_chid", 64'(id_r), 64'd0);
    chk("s1_nc", 64'(nc_r), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s1_hold_val", 64'(val_r), 64'd1);
      chk("s1_hold_addr", 64'(ad_r), 64'h12_40);
      chk("s1_hold_rqtype", 64'(rq_r), 64'(IMISS_RQ));
      chk("s1_hold_done", 64'(done_r), 64'd0);
    end
    ack = 1'b1;
    tick();
    chk("s1_done", 64'(done_r), 64'd1);
    chk("s1_val_drop", 64'(val_r), 64'd0);
    ack = 1'b0;
    tick();
    chk("s1_done_clear", 64'(done_r), 64'd0);

    // Same store data on ch1 (no swap) and ch2 (swapped).
    ch_rqtype[1] = STORE_RQ; ch_size[1] = 3'b011; ch_addr[1] = 40'h00_0000_0100;
    ch_data[1] = 64'h0102_0304_0506_0708;
    ch_rqtype[2] = STORE_RQ; ch_size[2] = 3'b011; ch_addr[2] = 40'h00_0000_0200;
    ch_data[2] = 64'h0102_0304_0506_0708;
    push(1, 1); push(2, 2);
    ch_val = 3'b110; ack = 1'b1;
    tick();
    ch_val = '0;
    repeat (2) tick();
    chk("s2_swapped_data", d_r, 64'h0807_0605_0403_0201);
    repeat (2) tick();
    chk("s2_idle_ack_done", 64'(done_r), 64'd0);
    chk("s2_idle_val", 64'(val_r), 64'd0);

    // Non-cacheable bit follows the address MSB.
    ch_rqtype[0] = LOAD_RQ; ch_size[0] = 3'b011; ch_addr[0] = 40'h80_0000_0000;
    push(0, 0);
    ch_val = 3'b001; tick(); ch_val = '0;
    repeat (4) tick();
    ch_addr[0] = 40'h7F_FFFF_FFC0;
    push(0, 0);
    ch_val = 3'b001; tick(); ch_val = '0;
    repeat (4) tick();

    // Pointer now at ch1: RR picks ch2 before ch0, fixed priority picks ch0 first.
    push(1, 1);
    ch_val = 3'b010; tick(); ch_val = '0;
    repeat (3) tick();
    push(2, 0); push(0, 2);
    ch_val = 3'b101; tick(); ch_val = '0;
    repeat (4) tick();
    ack = 1'b0;
    chk("s4_q_rr_empty", 64'(q_rr.size()), 64'd0);
    chk("s4_q_fp_empty", 64'(q_fp.size()), 64'd0);

    // All channels held requesting with ack held: RR rotates, FP starves ch2.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    push(0, 0); push(1, 1); push(2, 0); push(0, 1);
    push(1, 0); push(2, 1); push(0, 2);
    ch_val = 3'b111; ack = 1'b1;
    tick();
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("s5_rr_nobubble", 64'(val_r), 64'd1);
      chk("s5_fp_nobubble", 64'(val_f), 64'd1);
    end
    ch_val = '0;
    for (int i = 6; i <= 7; i++) begin
      tick();
      chk("s5_rr_drain", 64'(val_r), 64'd1);
      chk("s5_fp_drain", 64'(val_f), 64'd1);
    end
    tick();
    chk("s5_rr_idle", 64'(val_r), 64'd0);
    chk("s5_fp_idle", 64'(val_f), 64'd0);
    ack = 1'b0;
    chk("s5_q_rr_empty", 64'(q_rr.size()), 64'd0);
    chk("s5_q_fp_empty", 64'(q_fp.size()), 64'd0);
    tick();

    // Backpressure on ch1: a request while not ready is dropped.
    ch_rqtype[1] = LOAD_RQ; ch_addr[1] = 40'h00_0000_0300;
    push(1, 1);
    ch_val = 3'b010; tick();
    chk("s6_rdy_busy", 64'(rdy_r[1]), 64'd0);
    ch_addr[1] = 40'h00_0000_0340;
    tick();
    chk("s6_val", 64'(val_r), 64'd1);
    chk("s6_addr_a", 64'(ad_r), 64'h300);
    chk("s6_not_captured", 64'(rdy_r[1]), 64'd1);
    push(1, 1);
    tick();
    ch_val = '0;
    chk("s6_captured_b", 64'(rdy_r[1]), 64'd0);
    chk("s6_hold_a", 64'(ad_r), 64'h300);
    ack = 1'b1;
    tick();
    chk("s6_done1", 64'(done_r), 64'd2);
    chk("s6_b2b_val", 64'(val_r), 64'd1);
    chk("s6_b2b_addr", 64'(ad_r), 64'h340);
    tick();
    chk("s6_done2", 64'(done_r), 64'd2);
    chk("s6_val_drop", 64'(val_r), 64'd0);
    ack = 1'b0;
    tick();
    chk("s6_done_clear", 64'(done_r), 64'd0);
    chk("s6_q_rr_empty", 64'(q_rr.size()), 64'd0);

    // Reset with ch0 in flight and ch1 pending; ack during reset.
    ch_val = 3'b011; tick(); ch_val = '0;
    tick();
    chk("s7_val_pre", 64'(val_r), 64'd1);
    chk("s7_rdy_pre", 64'(rdy_r), 64'd5);
    rst_n = 1'b0; ack = 1'b1;
    tick();
    chk("s7_val_rst", 64'(val_r), 64'd0);
    chk("s7_val_rst_fp", 64'(val_f), 64'd0);
    chk("s7_rdy_rst", 64'(rdy_r), 64'd7);
    chk("s7_done_rst", 64'(done_r), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("s7_done_post", 64'(done_r), 64'd0);
    ack = 1'b0;
    repeat (2) tick();
    chk("s7_val_post", 64'(val_r), 64'd0);
    chk("s7_done_fp", 64'(done_f), 64'd0);
    chk("end_q_rr_empty", 64'(q_rr.size()), 64'd0);
    chk("end_q_fp_empty", 64'(q_fp.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
